// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//   Shared RV32I control definitions: opcode constants, the ALUctrl / wb_sel
//   encodings used by the datapath, the multi-cycle FSM states and the
//   instruction-class enum. classify() maps a 7-bit opcode to its class.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLTU   = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_PC4  = 2'b00,
    WB_ALU  = 2'b01,
    WB_LOAD = 2'b10
  } wb_sel_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } mc_state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR,
    CL_LUI, CL_AUIPC, CL_FENCE, CL_ILLEGAL
  } instr_class_e;

  // SYSTEM is not supported and falls through to CL_ILLEGAL.
  function automatic instr_class_e classify(input logic [6:0] opc);
    instr_class_e c;
    c = CL_ILLEGAL;
    if (opc[1:0] == 2'b11) begin
      case (opc)
        OP_OP:     c = CL_R;
        OP_IMM:    c = CL_I;
        OP_LOAD:   c = CL_LOAD;
        OP_STORE:  c = CL_STORE;
        OP_BRANCH: c = CL_BRANCH;
        OP_JAL:    c = CL_JAL;
        OP_JALR:   c = CL_JALR;
        OP_LUI:    c = CL_LUI;
        OP_AUIPC:  c = CL_AUIPC;
        OP_FENCE:  c = CL_FENCE;
        default:   c = CL_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/rv32i_mc_controller_if.sv
// rv32i_mc_controller_if
//   Instruction/data memory handshake between the controller (master) and
//   the memory side (slave).
//   imem_req/imem_ready : fetch request / instruction data valid
//   dmem_req/dmem_ready : data access request / access complete
//   mem_wr              : store (qualified by dmem_req)
//   load_ctrl           : funct3 of the load/store, 0 otherwise
interface rv32i_mc_controller_if;
  logic       imem_req;
  logic       imem_ready;
  logic       dmem_req;
  logic       dmem_ready;
  logic       mem_wr;
  logic [2:0] load_ctrl;

  modport master (output imem_req, dmem_req, mem_wr, load_ctrl,
                  input  imem_ready, dmem_ready);
  modport slave  (input  imem_req, dmem_req, mem_wr, load_ctrl,
                  output imem_ready, dmem_ready);
endinterface

// File: rtl/rv32i_alu_decode.sv
// rv32i_alu_decode
//   Combinational ALU operation decode, shared with the single-cycle core.
//   f7b5    in  funct7[5] (instr[30])
//   funct3  in  instr[14:12]
//   cls     in  instruction class
//   alu_op  out ALUctrl encoding
//   illegal_op out class illegal, or SUB/SRA funct7 on a funct3 that has none
module rv32i_alu_decode
  import rv32i_pkg::*;
(
  input  logic         f7b5,
  input  logic [2:0]   funct3,
  input  instr_class_e cls,
  output alu_op_e      alu_op,
  output logic         illegal_op
);

  alu_op_e base_op;

  always_comb begin
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  always_comb begin
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;
    case (cls)
      CL_R: begin
        alu_op = base_op;
        if (f7b5) begin
          if (funct3 == 3'b000)      alu_op = ALU_SUB;
          else if (funct3 == 3'b101) alu_op = ALU_SRA;
          else                       illegal_op = 1'b1;
        end
      end
      CL_I: begin
        // instr[30] is immediate data except on the shifts; ADDI never subtracts
        alu_op = base_op;
        if (f7b5 && funct3 == 3'b001) illegal_op = 1'b1;
        if (f7b5 && funct3 == 3'b101) alu_op = ALU_SRA;
      end
      CL_LUI:     alu_op = ALU_PASS_B;
      CL_ILLEGAL: illegal_op = 1'b1;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_controller.sv
// rv32i_mc_controller
//   Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP over a
//   shared datapath, with memory ready/valid handshakes, a bus timeout and
//   illegal-instruction trapping.
//   clk, rst (sync, active high), instruction, b_taken : inputs
//   mem     : memory handshake (master side)
//   ir_wr, ALUctrl, A_sel, B_sel, wb_sel, reg_wr, pc_wr, PC_sel : datapath control
//   illegal, bus_err : sticky trap flags;  state_o : FSM state
//   Control outputs are decoded from the registered state/class; the
//   ready-dependent strobes (ir_wr, store pc_wr) follow the ready input in
//   the same cycle so a zero-wait access costs one cycle.
module rv32i_mc_controller
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        b_taken,
  rv32i_mc_controller_if.master mem,
  output logic        ir_wr,
  output logic [3:0]  ALUctrl,
  output logic        A_sel,
  output logic        B_sel,
  output logic [1:0]  wb_sel,
  output logic        reg_wr,
  output logic        pc_wr,
  output logic        PC_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_o
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  mc_state_e    state_q, state_d;
  instr_class_e cls_q, cls_d;
  alu_op_e      alu_q, alu_d;
  logic [2:0]   f3_q, f3_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         illegal_q, illegal_d;
  logic         bus_err_q, bus_err_d;

  // ---- decode of the IR (valid in DECODE) ----
  instr_class_e cls_dec;
  alu_op_e      alu_dec;
  logic         alu_illegal, f7_bad, dec_illegal;
  logic         unused_fields;

  assign cls_dec       = classify(instruction[6:0]);
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  // R-type and the two shift-immediates allow only funct7 = 0x00 / 0x20
  assign f7_bad = ((cls_dec == CL_R) || (cls_dec == CL_I && instruction[13:12] == 2'b01))
                  && ({instruction[31], instruction[29:25]} != 6'd0);

  rv32i_alu_decode u_alu_decode (
    .f7b5       (instruction[30]),
    .funct3     (instruction[14:12]),
    .cls        (cls_dec),
    .alu_op     (alu_dec),
    .illegal_op (alu_illegal)
  );

  assign dec_illegal = f7_bad | alu_illegal;

  // Limit reached on this not-ready cycle; a ready in the same cycle wins.
  logic tmo_hit;
  assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT - 1));

  // ---- next state ----
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    alu_d     = alu_q;
    f3_d      = f3_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (mem.imem_ready) state_d = S_DECODE;
        else if (tmo_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_DECODE: begin
        cls_d = cls_dec;
        alu_d = alu_dec;
        f3_d  = instruction[14:12];
        if (dec_illegal) begin
          if (ILLEGAL_TRAP) begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end else state_d = S_FETCH;
        end else if (cls_dec == CL_FENCE) state_d = S_FETCH;
        else state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          CL_LOAD, CL_STORE:           state_d = S_MEM;
          CL_BRANCH, CL_JAL, CL_JALR:  state_d = S_FETCH;
          default:                     state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem.dmem_ready) state_d = (cls_q == CL_STORE) ? S_FETCH : S_WB;
        else if (tmo_hit) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= CL_ILLEGAL;
      alu_q     <= ALU_ADD;
      f3_q      <= 3'd0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      alu_q     <= alu_d;
      f3_q      <= f3_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // ---- output decode; everything forced low while rst is high ----
  logic imem_req_o, dmem_req_o, mem_wr_o;
  logic [2:0] load_ctrl_o;

  always_comb begin
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    mem_wr_o    = 1'b0;
    load_ctrl_o = 3'd0;
    ir_wr       = 1'b0;
    ALUctrl     = 4'd0;
    A_sel       = 1'b0;
    B_sel       = 1'b0;
    wb_sel      = WB_PC4;
    reg_wr      = 1'b0;
    pc_wr       = 1'b0;
    PC_sel      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req_o = 1'b1;
          ir_wr      = mem.imem_ready;
        end
        S_DECODE: begin
          // illegal-as-NOP and FENCE retire here with PC+4
          if ((dec_illegal && !ILLEGAL_TRAP) || (!dec_illegal && cls_dec == CL_FENCE))
            pc_wr = 1'b1;
        end
        S_EXEC, S_MEM, S_WB: begin
          ALUctrl = alu_q;
          case (cls_q)
            CL_R:                               A_sel = 1'b1;
            CL_I, CL_LOAD, CL_STORE, CL_JALR:   begin A_sel = 1'b1; B_sel = 1'b1; end
            CL_BRANCH, CL_JAL, CL_LUI, CL_AUIPC: B_sel = 1'b1;
            default: ;
          endcase
          if (cls_q == CL_LOAD || cls_q == CL_STORE) load_ctrl_o = f3_q;
          if (state_q == S_EXEC) begin
            if (cls_q == CL_BRANCH) begin
              pc_wr  = 1'b1;
              PC_sel = b_taken;
            end else if (cls_q == CL_JAL || cls_q == CL_JALR) begin
              reg_wr = 1'b1;
              pc_wr  = 1'b1;
              PC_sel = 1'b1;
            end
          end else if (state_q == S_MEM) begin
            dmem_req_o = 1'b1;
            mem_wr_o   = (cls_q == CL_STORE);
            pc_wr      = (cls_q == CL_STORE) && mem.dmem_ready;
          end else begin
            reg_wr = 1'b1;
            pc_wr  = 1'b1;
            wb_sel = (cls_q == CL_LOAD) ? WB_LOAD : WB_ALU;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.imem_req  = imem_req_o;
  assign mem.dmem_req  = dmem_req_o;
  assign mem.mem_wr    = mem_wr_o;
  assign mem.load_ctrl = load_ctrl_o;
  assign illegal       = illegal_q & ~rst;
  assign bus_err       = bus_err_q & ~rst;
  assign state_o       = rst ? 3'd0 : state_q;

endmodule
